// File: rtl/bird_matrix_scanner.sv
// bird_matrix_scanner: 8x8 RGB LED column scanner with frame-latched bird/obstacle shadows.
// Optional macro BIRD_BLINK_EN blinks the bird layer at half frame rate while gameOver is latched.
`default_nettype none

module bird_matrix_scanner #(
  parameter int DWELL    = 1000,
  parameter int BLANK    = 2,
  parameter int BIRD_COL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] head,
  input  logic [23:0] tail,
  input  logic        gameOver,
  input  logic [63:0] obstacle,
  output logic [7:0]  col_sel,
  output logic [23:0] row_data,
  output logic        frame_done,
  output logic        collision
);

  localparam int             CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]  c_cnt_last = CW'(DWELL - 1);
  localparam logic [2:0]     c_tail_col = 3'(BIRD_COL);
  localparam logic [2:0]     c_head_col = 3'(BIRD_COL + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    col_q, col_d;
  logic [23:0]   head_q, head_d;
  logic [23:0]   tail_q, tail_d;
  logic [63:0]   obs_q, obs_d;
  logic [7:0]    col_sel_q, col_sel_d;
  logic [23:0]   row_data_q, row_data_d;
  logic          frame_done_q, frame_done_d;
  logic          collision_q, collision_d;

  logic          w_wrap;
  logic          w_boundary;
  logic          w_blank;
  logic          w_hide;
  logic [7:0]    w_obs_col;
  logic [23:0]   w_bird;
  logic [7:0]    w_head_any;
  logic [7:0]    w_tail_any;
  logic          w_hit;

  generate
    if (BLANK > 0) begin : g_blank
      assign w_blank = (cnt_q < CW'(BLANK));
    end else begin : g_no_blank
      assign w_blank = 1'b0;
    end
  endgenerate

`ifdef BIRD_BLINK_EN
  logic go_q, go_d;
  logic blink_q, blink_d;

  always_comb begin
    go_d    = go_q;
    blink_d = blink_q;
    if (w_boundary) begin
      go_d    = gameOver;
      blink_d = gameOver ? ~blink_q : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      go_q    <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      go_q    <= go_d;
      blink_q <= blink_d;
    end
  end

  assign w_hide = blink_q & go_q;
`else
  logic w_unused_go;
  assign w_unused_go = gameOver;
  assign w_hide      = 1'b0;
`endif

  always_comb begin
    w_wrap     = (cnt_q == c_cnt_last);
    w_boundary = w_wrap && (col_q == 3'd7);
    cnt_d      = w_wrap ? '0 : cnt_q + 1'b1;
    col_d      = w_wrap ? col_q + 3'd1 : col_q;

    w_obs_col = obs_q[{col_q, 3'b000} +: 8];
    w_bird    = 24'h0;
    if (col_q == c_tail_col) begin
      w_bird = tail_q;
    end else if (col_q == c_head_col) begin
      w_bird = head_q;
    end
    if (w_hide) begin
      w_bird = 24'h0;
    end

    col_sel_d    = 8'h01 << col_q;
    row_data_d   = w_blank ? 24'h0 : ({16'h0, w_obs_col} | w_bird);
    frame_done_d = w_boundary;

    // Collision is judged on the values being latched, so it matches the frame about to be shown.
    w_head_any = head[7:0] | head[15:8] | head[23:16];
    w_tail_any = tail[7:0] | tail[15:8] | tail[23:16];
    w_hit      = (|(w_head_any & obstacle[8*(BIRD_COL+1) +: 8])) |
                 (|(w_tail_any & obstacle[8*BIRD_COL +: 8]));

    collision_d = w_boundary ? w_hit    : collision_q;
    head_d      = w_boundary ? head     : head_q;
    tail_d      = w_boundary ? tail     : tail_q;
    obs_d       = w_boundary ? obstacle : obs_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      col_q        <= 3'd0;
      head_q       <= 24'h0;
      tail_q       <= 24'h0;
      obs_q        <= 64'h0;
      col_sel_q    <= 8'h01;
      row_data_q   <= 24'h0;
      frame_done_q <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      obs_q        <= obs_d;
      col_sel_q    <= col_sel_d;
      row_data_q   <= row_data_d;
      frame_done_q <= frame_done_d;
      collision_q  <= collision_d;
    end
  end

  assign col_sel    = col_sel_q;
  assign row_data   = row_data_q;
  assign frame_done = frame_done_q;
  assign collision  = collision_q;

endmodule

`default_nettype wire

// File: tb/tb_bird_matrix_scanner.sv
// Testbench for bird_matrix_scanner: random stimulus against a time-indexed reference model.
`default_nettype none

module tb_bird_matrix_scanner;

  localparam int DWELL    = 4;
  localparam int BLANK    = 1;
  localparam int BIRD_COL = 1;
  localparam int FRAME    = 8 * DWELL;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] head, tail;
  logic        gameOver;
  logic [63:0] obstacle;
  logic [7:0]  col_sel;
  logic [23:0] row_data;
  logic        frame_done, collision;

  bird_matrix_scanner #(
    .DWELL    (DWELL),
    .BLANK    (BLANK),
    .BIRD_COL (BIRD_COL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .head       (head),
    .tail       (tail),
    .gameOver   (gameOver),
    .obstacle   (obstacle),
    .col_sel    (col_sel),
    .row_data   (row_data),
    .frame_done (frame_done),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_t is the scan time (cycles since reset release) of the cycle in progress.
  int          m_t;
  logic [23:0] s_head, s_tail;
  logic [63:0] s_obs;
  logic [7:0]  e_col_sel;
  logic [23:0] e_row;
  logic        e_fd, e_coll;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    int cnt, col;
    @(posedge clk);
    if (reset) begin
      m_t = 0; s_head = '0; s_tail = '0; s_obs = '0;
      e_col_sel = 8'h01; e_row = '0; e_fd = 1'b0; e_coll = 1'b0;
    end else begin
      cnt = m_t % DWELL;
      col = (m_t / DWELL) % 8;
      e_col_sel = 8'(1 << col);
      e_row = '0;
      if (cnt >= BLANK) begin
        e_row[7:0] = s_obs[8*col +: 8];
        if (col == BIRD_COL)          e_row = e_row | s_tail;
        else if (col == BIRD_COL + 1) e_row = e_row | s_head;
      end
      e_fd = (m_t % FRAME == FRAME - 1);
      if (e_fd) begin
        s_head = head; s_tail = tail; s_obs = obstacle;
        e_coll = 1'b0;
        for (int r = 0; r < 8; r++) begin
          if ((head[r] | head[8+r] | head[16+r]) && obstacle[8*(BIRD_COL+1) + r]) e_coll = 1'b1;
          if ((tail[r] | tail[8+r] | tail[16+r]) && obstacle[8*BIRD_COL + r])     e_coll = 1'b1;
        end
      end
      m_t++;
    end
    @(negedge clk);
    chk("col_sel", col_sel, e_col_sel);
    chk("row_data", row_data, e_row);
    chk("frame_done", frame_done, e_fd);
    chk("collision", collision, e_coll);
  endtask

  initial begin
    int fd_count, fd_at;
    bit found;
    reset = 1'b1; head = '0; tail = '0; gameOver = 1'b0; obstacle = '0;
    m_t = 0; s_head = '0; s_tail = '0; s_obs = '0;
    @(negedge clk);

    repeat (3) tick();
    chk("rst_col_sel", col_sel, 8'h01);
    chk("rst_row", row_data, 24'h0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_coll", collision, 1'b0);

    // Plain scan: first frame_done after 32 edges, exactly once in 40
    reset = 1'b0;
    fd_count = 0; fd_at = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (frame_done) begin
        fd_count++;
        if (fd_at == 0) fd_at = i;
      end
    end
    chk("fd_edge", fd_at, 32);
    chk("fd_count", fd_count, 1);

    // Bird over an obstacle in the head column
    reset = 1'b1; tick(); reset = 1'b0;
    head = 24'h000800; tail = 24'h000004; obstacle = 64'h1 << 19;
    repeat (42) tick();
    chk("hit_row", row_data, 24'h000808);
    chk("hit_coll", collision, 1'b1);
    obstacle = '0;
    repeat (21) tick();
    chk("coll_hold", collision, 1'b1);
    tick();
    chk("coll_clear", collision, 1'b0);

    // Mid-frame reset at col 5, cnt 2 while collision is set
    obstacle = 64'h1 << 19;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (collision && (m_t % FRAME == 5 * DWELL + 2)) found = 1'b1;
      else tick();
    end
    chk("seek_mid", found, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_fd", frame_done, 1'b0);
    chk("mid_col_sel", col_sel, 8'h01);
    chk("mid_row", row_data, 24'h0);
    chk("mid_coll", collision, 1'b0);

    // Random inputs every cycle; shadows must only pick them up at frame boundaries
    for (int i = 0; i < 1200; i++) begin
      head     = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
      tail     = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
      obstacle = {$urandom, $urandom} & {$urandom, $urandom};
      gameOver = 1'($urandom);
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
